// File: rtl/ct_l2c_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2c_sram_pkg
// Description : Shared types and constants for the L2C single-port SRAM
//               sequencer/arbiter: geometry constants, sequencer state
//               encoding and the requester payload struct.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_l2c_sram_pkg;

    localparam int c_ADDR_WIDTH = 10;
    localparam int c_DATA_WIDTH = 128;
    localparam int c_DEPTH      = 1024;

    // Sequencer state: zero-fill sweep, then arbitrated service.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One requester's view of the SRAM port.
    typedef struct packed {
        logic                    vld;
        logic                    wr;
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
        logic [c_DATA_WIDTH-1:0] wmask;
    } req_t;

endpackage : ct_l2c_sram_pkg
`default_nettype wire

// File: rtl/ct_l2c_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2c_rr_arb2
// Description : Two-way round-robin arbiter. A sole requester always wins;
//               on contention the requester selected by rr_ptr wins. After
//               any grant rr_ptr points at the requester that did not win.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (rr_ptr -> 0)
//               i_req    - request vector, bit N = requester N
//               o_gnt    - one-hot grant, combinational from i_req/rr_ptr
// Revision    : 1.0 - initial release
// ============================================================================
module ct_l2c_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_rr_ptr;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_rr_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // Winner 0 -> point at 1, winner 1 -> point at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (|i_req) begin
            r_rr_ptr <= ~o_gnt[1];
        end
    end

endmodule : ct_l2c_rr_arb2
`default_nettype wire

// File: rtl/ct_l2c_spsram_arb.sv
`default_nettype none
// ============================================================================
// Module      : ct_l2c_spsram_arb
// Description : Sequencer and arbiter for one single-port L2C SRAM macro.
//               Optionally zero-fills every entry after reset, then shares
//               the port between two valid/grant requesters (round-robin).
//               Read data is returned one cycle after grant, tagged with the
//               requester index; writes return nothing.
// Config      : L2C_SRAM_INIT_EN - when defined, the post-reset zero-fill
//               sweep is present and init_done marks its completion; when
//               undefined the block starts in service and init_done = 1.
// Ports       : forever_cpuclk / cpurst      - clock, sync active-high reset
//               reqN_vld/wr/addr/wdata/wmask - requester N payload (N=0,1)
//               reqN_gnt                     - requester N accepted this cycle
//               rd_vld/rd_id/rd_data         - read return (rd_data = sram_q)
//               init_done                    - port open to requesters
//               sram_cen/gwen/wen/a/d        - macro pins (active-low enables)
//               sram_q                       - macro read data
// Revision    : 1.0 - initial release
// ============================================================================
module ct_l2c_spsram_arb
    import ct_l2c_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  req0_gnt,
    output logic                  req1_gnt,
    output logic                  rd_vld,
    output logic                  rd_id,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    // The sweep counter relies on wrapping exactly at the last entry.
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end

    req_t       w_req0;
    req_t       w_req1;
    req_t       w_win;
    logic [1:0] w_gnt;
    logic       w_run;
    logic       w_open;
    logic       w_issue;
    logic       r_rd_vld;
    logic       r_rd_id;

`ifdef L2C_SRAM_INIT_EN
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            w_state_nxt = ST_RUN;
        end
    end

    assign w_run = (r_state == ST_RUN);
`else
    assign w_run = 1'b1;
`endif

    assign init_done = w_run;

    // Requests are only visible to the arbiter in service and out of reset,
    // so the arbiter pointer never moves during the sweep or reset.
    assign w_open = w_run & ~cpurst;

    assign w_req0 = '{vld: req0_vld, wr: req0_wr, addr: req0_addr,
                      wdata: req0_wdata, wmask: req0_wmask};
    assign w_req1 = '{vld: req1_vld, wr: req1_wr, addr: req1_addr,
                      wdata: req1_wdata, wmask: req1_wmask};

    ct_l2c_rr_arb2 u_arb (
        .clk   (forever_cpuclk),
        .rst   (cpurst),
        .i_req ({w_req1.vld, w_req0.vld} & {2{w_open}}),
        .o_gnt (w_gnt)
    );

    assign req0_gnt = w_gnt[0];
    assign req1_gnt = w_gnt[1];
    assign w_win    = w_gnt[1] ? w_req1 : w_req0;
    assign w_issue  = (|w_gnt) & w_win.vld;

    // Pin mux: reset forces idle, then sweep write, then granted access.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (cpurst) begin
            sram_cen = 1'b1;
`ifdef L2C_SRAM_INIT_EN
        end else if (r_state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = r_cnt;
`endif
        end else if (w_issue) begin
            sram_cen = 1'b0;
            sram_a   = w_win.addr;
            if (w_win.wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~w_win.wmask;
                sram_d    = w_win.wdata;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rd_vld <= 1'b0;
            r_rd_id  <= 1'b0;
        end else begin
            r_rd_vld <= w_issue & ~w_win.wr;
            if (w_issue && !w_win.wr) begin
                r_rd_id <= w_gnt[1];
            end
        end
    end

    assign rd_vld  = r_rd_vld;
    assign rd_id   = r_rd_id;
    assign rd_data = sram_q;

endmodule : ct_l2c_spsram_arb
`default_nettype wire

// File: tb/tb_ct_l2c_spsram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_l2c_spsram_arb
// Description : Directed self-checking bench for ct_l2c_spsram_arb with a
//               behavioural single-port SRAM macro. Adapts to
//               L2C_SRAM_INIT_EN being defined or not.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_l2c_spsram_arb;

    localparam int AW = 10;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          cpurst;
    logic          req0_vld, req0_wr, req1_vld, req1_wr;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req0_wmask, req1_wdata, req1_wmask;
    logic          req0_gnt, req1_gnt, rd_vld, rd_id, init_done;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, rd_data;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    localparam logic [DW-1:0] PAT_A5  = {16{8'hA5}};
    localparam logic [DW-1:0] ONES    = {DW{1'b1}};
    localparam logic [DW-1:0] LO_MASK = {{64{1'b0}}, {64{1'b1}}};
    localparam logic [DW-1:0] HI_DATA = {{64{1'b1}}, {64{1'b0}}};

    always #5 clk = ~clk;

    ct_l2c_spsram_arb dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .req0_vld       (req0_vld),
        .req0_wr        (req0_wr),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_wmask     (req0_wmask),
        .req1_vld       (req1_vld),
        .req1_wr        (req1_wr),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_wmask     (req1_wmask),
        .req0_gnt       (req0_gnt),
        .req1_gnt       (req1_gnt),
        .rd_vld         (rd_vld),
        .rd_id          (rd_id),
        .rd_data        (rd_data),
        .init_done      (init_done),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // Behavioural macro: active-low enables, per-bit write, registered read.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end
            sram_q <= mem[sram_a];
        end
    end

    // Each cycle starts 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        req0_vld = v; req0_wr = w; req0_addr = a; req0_wdata = d; req0_wmask = m;
    endtask

    task automatic set_req1(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        req1_vld = v; req1_wr = w; req1_addr = a; req1_wdata = d; req1_wmask = m;
    endtask

    task automatic test_reset();
        cpurst = 1'b1;
        set_req0(1'b1, 1'b0, 10'h3FF, '0, '0);
        set_req1(1'b1, 1'b0, 10'h3FF, '0, '0);
        tick();
        tick();
        checks++;
        if ({req0_gnt, req1_gnt, rd_vld, rd_id} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: gnt0=%b gnt1=%b rd_vld=%b rd_id=%b, want all 0",
                     req0_gnt, req1_gnt, rd_vld, rd_id);
        end
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== ONES) begin
            failures++;
            $display("FAIL reset_pins: cen=%b gwen=%b wen=%h, want 1 1 all-ones",
                     sram_cen, sram_gwen, sram_wen);
        end
        checks++;
`ifdef L2C_SRAM_INIT_EN
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_init_done: got %b want 0", init_done);
        end
`else
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL reset_init_done: got %b want 1", init_done);
        end
`endif
    endtask

`ifdef L2C_SRAM_INIT_EN
    // Both requesters hold vld through the sweep; none may be granted.
    task automatic test_init_sweep();
        cpurst = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) begin
            checks++;
            if ({req0_gnt, req1_gnt, sram_cen, sram_gwen, init_done} !== 5'b0 ||
                sram_wen !== '0 || sram_d !== '0 || sram_a !== AW'(i)) begin
                failures++;
                $display("FAIL sweep_cycle_%0d: gnt=%b%b cen=%b gwen=%b done=%b a=%h wen0=%b, want a=%h rest 0",
                         i, req1_gnt, req0_gnt, sram_cen, sram_gwen, init_done,
                         sram_a, (sram_wen == '0), AW'(i));
            end
            tick();
        end
        checks++;
        if (init_done !== 1'b1 || req0_gnt !== 1'b1 || req1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL sweep_first_grant: done=%b gnt0=%b gnt1=%b, want 1 1 0",
                     init_done, req0_gnt, req1_gnt);
        end
        tick();
        set_req0(1'b0, 1'b0, '0, '0, '0);
        set_req1(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rd_vld !== 1'b1 || rd_id !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL sweep_read_3ff: rd_vld=%b rd_id=%b data=%h, want 1 0 0",
                     rd_vld, rd_id, rd_data);
        end
        tick();
    endtask
`else
    task automatic test_first_cycle();
        set_req0(1'b0, 1'b0, '0, '0, '0);
        set_req1(1'b1, 1'b0, 10'h005, '0, '0);
        cpurst = 1'b0;
        #1;
        checks++;
        if (req1_gnt !== 1'b1 || req0_gnt !== 1'b0 || init_done !== 1'b1 ||
            sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_a !== 10'h005) begin
            failures++;
            $display("FAIL first_cycle_grant: gnt1=%b gnt0=%b done=%b cen=%b gwen=%b a=%h, want 1 0 1 0 1 005",
                     req1_gnt, req0_gnt, init_done, sram_cen, sram_gwen, sram_a);
        end
        tick();
        set_req1(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rd_vld !== 1'b1 || rd_id !== 1'b1 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL first_cycle_return: rd_vld=%b rd_id=%b done=%b, want 1 1 1",
                     rd_vld, rd_id, init_done);
        end
        tick();
    endtask
`endif

    task automatic test_read_path();
        set_req0(1'b0, 1'b0, '0, '0, '0);
        set_req1(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== ONES ||
            sram_a !== '0 || sram_d !== '0 || req0_gnt !== 1'b0 || req1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL idle_pins: cen=%b gwen=%b a=%h gnt=%b%b, want idle",
                     sram_cen, sram_gwen, sram_a, req1_gnt, req0_gnt);
        end
        set_req0(1'b1, 1'b1, 10'h012, PAT_A5, ONES);
        #1;
        checks++;
        if (req0_gnt !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
            sram_wen !== '0 || sram_a !== 10'h012 || sram_d !== PAT_A5) begin
            failures++;
            $display("FAIL write_issue: gnt0=%b cen=%b gwen=%b a=%h d=%h, want 1 0 0 012 a5..",
                     req0_gnt, sram_cen, sram_gwen, sram_a, sram_d);
        end
        tick();
        set_req0(1'b1, 1'b0, 10'h012, '0, '0);
        #1;
        checks++;
        if (req0_gnt !== 1'b1 || rd_vld !== 1'b0 || sram_gwen !== 1'b1 || sram_wen !== ONES) begin
            failures++;
            $display("FAIL read_issue: gnt0=%b rd_vld=%b gwen=%b wen_ones=%b, want 1 0 1 1",
                     req0_gnt, rd_vld, sram_gwen, (sram_wen == ONES));
        end
        tick();
        set_req0(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rd_vld !== 1'b1 || rd_id !== 1'b0 || rd_data !== PAT_A5) begin
            failures++;
            $display("FAIL read_return: rd_vld=%b rd_id=%b data=%h, want 1 0 a5..",
                     rd_vld, rd_id, rd_data);
        end
        tick();
        checks++;
        if (rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL read_single_pulse: rd_vld=%b want 0", rd_vld);
        end
    endtask

    task automatic test_masked_write();
        set_req1(1'b1, 1'b1, 10'h100, ONES, ONES);
        #1;
        checks++;
        if (req1_gnt !== 1'b1 || sram_a !== 10'h100) begin
            failures++;
            $display("FAIL mask_fill: gnt1=%b a=%h, want 1 100", req1_gnt, sram_a);
        end
        tick();
        set_req1(1'b1, 1'b1, 10'h100, '0, LO_MASK);
        #1;
        checks++;
        if (req1_gnt !== 1'b1 || sram_wen !== ~LO_MASK || sram_gwen !== 1'b0 || sram_d !== '0) begin
            failures++;
            $display("FAIL mask_wen: gnt1=%b wen=%h gwen=%b, want 1 %h 0",
                     req1_gnt, sram_wen, sram_gwen, ~LO_MASK);
        end
        tick();
        set_req1(1'b1, 1'b0, 10'h100, '0, '0);
        #1;
        tick();
        set_req1(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rd_vld !== 1'b1 || rd_id !== 1'b1 || rd_data !== HI_DATA) begin
            failures++;
            $display("FAIL mask_read: rd_vld=%b rd_id=%b data=%h, want 1 1 %h",
                     rd_vld, rd_id, rd_data, HI_DATA);
        end
        tick();
    endtask

    // Both read every cycle; rr_ptr is 0 here (last grant went to req1).
    task automatic test_contention();
        logic [1:0]    exp_gnt;
        logic          exp_id;
        logic [DW-1:0] exp_data;
        set_req0(1'b1, 1'b0, 10'h012, '0, '0);
        set_req1(1'b1, 1'b0, 10'h100, '0, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({req1_gnt, req0_gnt} !== exp_gnt) begin
                failures++;
                $display("FAIL contention_gnt_%0d: gnt=%b want %b", k, {req1_gnt, req0_gnt}, exp_gnt);
            end
            if (k > 0) begin
                exp_id   = (k % 2 == 0);
                exp_data = exp_id ? HI_DATA : PAT_A5;
                checks++;
                if (rd_vld !== 1'b1 || rd_id !== exp_id || rd_data !== exp_data) begin
                    failures++;
                    $display("FAIL contention_rd_%0d: rd_vld=%b rd_id=%b data=%h, want 1 %b %h",
                             k, rd_vld, rd_id, rd_data, exp_id, exp_data);
                end
            end
            tick();
        end
        set_req0(1'b0, 1'b0, '0, '0, '0);
        set_req1(1'b0, 1'b0, '0, '0, '0);
        #1;
        checks++;
        if (rd_vld !== 1'b1 || rd_id !== 1'b1 || rd_data !== HI_DATA) begin
            failures++;
            $display("FAIL contention_rd_last: rd_vld=%b rd_id=%b, want 1 1", rd_vld, rd_id);
        end
        tick();
    endtask

    task automatic test_reset_read();
        set_req1(1'b1, 1'b0, 10'h100, '0, '0);
        #1;
        checks++;
        if (req1_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_grant: gnt1=%b want 1", req1_gnt);
        end
        tick();
        set_req1(1'b0, 1'b0, '0, '0, '0);
        set_req0(1'b1, 1'b0, 10'h012, '0, '0);
        cpurst = 1'b1;
        #1;
        checks++;
        if (req0_gnt !== 1'b0 || rd_vld !== 1'b1 || rd_id !== 1'b1 || sram_cen !== 1'b1) begin
            failures++;
            $display("FAIL rst_rd_inflight: gnt0=%b rd_vld=%b rd_id=%b cen=%b, want 0 1 1 1",
                     req0_gnt, rd_vld, rd_id, sram_cen);
        end
        tick();
        checks++;
        if (rd_vld !== 1'b0 || rd_id !== 1'b0) begin
            failures++;
            $display("FAIL rst_rd_cleared: rd_vld=%b rd_id=%b, want 0 0", rd_vld, rd_id);
        end
        set_req0(1'b0, 1'b0, '0, '0, '0);
        cpurst = 1'b0;
        #1;
    endtask

`ifdef L2C_SRAM_INIT_EN
    task automatic test_reset_mid();
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        #1;
        for (int i = 0; i < 500; i++) tick();
        cpurst = 1'b1;
        #1;
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_idle: cen=%b gwen=%b, want 1 1", sram_cen, sram_gwen);
        end
        tick();
        cpurst = 1'b0;
        #1;
        checks++;
        if (sram_a !== '0 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_restart: a=%h cen=%b gwen=%b done=%b, want 000 0 0 0",
                     sram_a, sram_cen, sram_gwen, init_done);
        end
        for (int i = 1; i < 1024; i++) tick();
        checks++;
        if (init_done !== 1'b0 || sram_a !== 10'h3FF) begin
            failures++;
            $display("FAIL mid_rst_cycle1023: done=%b a=%h, want 0 3ff", init_done, sram_a);
        end
        tick();
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_done: done=%b want 1", init_done);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef L2C_SRAM_INIT_EN
        test_init_sweep();
`else
        test_first_cycle();
`endif
        test_read_path();
        test_masked_write();
        test_contention();
        test_reset_read();
`ifdef L2C_SRAM_INIT_EN
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ct_l2c_spsram_arb
`default_nettype wire
